// File: rtl/tron_pkg.sv
// Shared definitions for the Tron plot path: phase codes, colours, palette and pos field helpers.
package tron_pkg;

  typedef enum logic [1:0] {
    PH_CLEAR = 2'b00,
    PH_ROUND = 2'b01,
    PH_WIN   = 2'b10,
    PH_DONE  = 2'b11
  } phase_t;

  localparam logic [23:0] DEFAULT_PALETTE = 24'o67421;
  localparam logic [2:0]  BLACK = 3'b000;
  localparam logic [2:0]  WHITE = 3'b111;

  // pos fields are packed {x,y}; x sits above the y_w low bits
  function automatic logic [15:0] POS_X(input logic [31:0] field, input int unsigned y_w);
    logic [31:0] s;
    s = field >> y_w;
    return s[15:0];
  endfunction

  function automatic logic [15:0] POS_Y(input logic [31:0] field, input int unsigned y_w);
    logic [31:0] m;
    m = field & ((32'd1 << y_w) - 32'd1);
    return m[15:0];
  endfunction

endpackage

// File: rtl/rect_sweeper.sv
// Raster sweep of a rectangle, y outer and x inner; one coordinate per cycle after start.
module rect_sweeper #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [X_W-1:0] origin_x,
  input  logic [Y_W-1:0] origin_y,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           valid,
  output logic           last
);

  logic           active;
  logic [X_W-1:0] cx, ox, w_q;
  logic [Y_W-1:0] cy, oy, h_q;
  logic           x_end, y_end;

  assign x_end = (cx == w_q - X_W'(1));
  assign y_end = (cy == h_q - Y_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cx     <= '0;
      cy     <= '0;
      ox     <= '0;
      oy     <= '0;
      w_q    <= '0;
      h_q    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cx     <= '0;
      cy     <= '0;
      ox     <= origin_x;
      oy     <= origin_y;
      w_q    <= width;
      h_q    <= height;
    end else if (active) begin
      if (x_end) begin
        cx <= '0;
        if (y_end) active <= 1'b0;
        else       cy     <= cy + Y_W'(1);
      end else begin
        cx <= cx + X_W'(1);
      end
    end
  end

  assign x     = ox + cx;
  assign y     = oy + cy;
  assign valid = active;
  assign last  = active && x_end && y_end;

endmodule

// File: rtl/plot_sequencer.sv
// Time-multiplexes one VGA plot port across screen clear, player heads, timer bar and winner badge.
module plot_sequencer
  import tron_pkg::*;
#(
  parameter int          N_PLAYERS = 4,
  parameter int          X_W       = 8,
  parameter int          Y_W       = 7,
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter int          TIMER_Y   = 119,
  parameter int          TIMER_LEN = 159,
  parameter int          WIN_SIZE  = 8,
  parameter logic [23:0] PALETTE   = DEFAULT_PALETTE,
  localparam int         IDX_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int         PW        = X_W + Y_W
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    tick,
  input  logic                    game_over,
  input  logic                    restart,
  input  logic [IDX_W-1:0]        winner,
  input  logic [N_PLAYERS-1:0]    alive,
  input  logic [N_PLAYERS*PW-1:0] pos,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [2:0]              colour,
  output logic                    plot,
  output logic                    running,
  output logic [1:0]              phase
);

  localparam int SLOT_W = $clog2(N_PLAYERS + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_PLAYERS);
  localparam logic [X_W-1:0] WIN_X0 = X_W'((SCREEN_W - WIN_SIZE) / 2);
  localparam logic [Y_W-1:0] WIN_Y0 = Y_W'((SCREEN_H - WIN_SIZE) / 2);

  // S_BOOT is the one idle CLEAR cycle after reset that launches the sweep
  typedef enum logic [2:0] {S_BOOT, S_CLEAR, S_ROUND, S_WIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [X_W-1:0]     timer_q;
  logic [IDX_W-1:0]   winner_q;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [2:0]         colour_q, colour_d;
  logic               plot_q, plot_d;

  logic               sw_start, sw_valid, sw_last;
  logic [X_W-1:0]     sw_ox, sw_w, sw_x;
  logic [Y_W-1:0]     sw_oy, sw_h, sw_y;

  logic [PW-1:0]      pos_f;
  logic [2:0]         slot_colour, win_colour;
  logic               slot_alive;
  phase_t             ph;

  assign pos_f       = PW'(pos >> (PW * int'(slot_q)));
  assign slot_colour = 3'(PALETTE >> (3 * int'(slot_q)));
  assign slot_alive  = 1'(alive >> slot_q);
  assign win_colour  = (int'(winner_q) < N_PLAYERS) ? 3'(PALETTE >> (3 * int'(winner_q))) : WHITE;

  rect_sweeper #(.X_W(X_W), .Y_W(Y_W)) u_sweep (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .start    (sw_start),
    .origin_x (sw_ox),
    .origin_y (sw_oy),
    .width    (sw_w),
    .height   (sw_h),
    .x        (sw_x),
    .y        (sw_y),
    .valid    (sw_valid),
    .last     (sw_last)
  );

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    sw_start = 1'b0;
    sw_ox    = '0;
    sw_oy    = '0;
    sw_w     = X_W'(SCREEN_W);
    sw_h     = Y_W'(SCREEN_H);
    case (state_q)
      S_BOOT: begin
        sw_start = 1'b1;
        state_d  = S_CLEAR;
      end
      S_CLEAR: begin
        x_d      = sw_x;
        y_d      = sw_y;
        colour_d = BLACK;
        plot_d   = sw_valid;
        slot_d   = '0;
        if (sw_last) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (slot_q == LAST_SLOT) begin
          x_d      = timer_q;
          y_d      = Y_W'(TIMER_Y);
          colour_d = WHITE;
          plot_d   = 1'b1;
          slot_d   = '0;
          // exit only at the timer slot so every round is drawn in full
          if (timer_q == X_W'(TIMER_LEN) || game_over) begin
            state_d  = S_WIN;
            sw_start = 1'b1;
            sw_ox    = WIN_X0;
            sw_oy    = WIN_Y0;
            sw_w     = X_W'(WIN_SIZE);
            sw_h     = Y_W'(WIN_SIZE);
          end
        end else begin
          x_d      = X_W'(POS_X(32'(pos_f), Y_W));
          y_d      = Y_W'(POS_Y(32'(pos_f), Y_W));
          colour_d = slot_colour;
          plot_d   = slot_alive;
          slot_d   = slot_q + SLOT_W'(1);
        end
      end
      S_WIN: begin
        x_d      = sw_x;
        y_d      = sw_y;
        colour_d = win_colour;
        plot_d   = sw_valid;
        if (sw_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (restart) begin
          state_d  = S_CLEAR;
          sw_start = 1'b1;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_BOOT;
      slot_q   <= '0;
      timer_q  <= '0;
      winner_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      if (state_q == S_ROUND && state_d == S_WIN) winner_q <= winner;
      if (state_q == S_DONE && restart)
        timer_q <= '0;
      else if (state_q == S_ROUND && tick && timer_q < X_W'(TIMER_LEN))
        timer_q <= timer_q + X_W'(1);
    end
  end

  always_comb begin
    ph = PH_CLEAR;
    case (state_q)
      S_ROUND: ph = PH_ROUND;
      S_WIN:   ph = PH_WIN;
      S_DONE:  ph = PH_DONE;
      default: ph = PH_CLEAR;
    endcase
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign running = (state_q == S_ROUND);
  assign phase   = ph;

endmodule
